// File: rtl/wb_result_unit_pkg.sv
// Shared encodings for the write-back result unit.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
//
// Contents: WB_SEL source encodings, LD_SIZE encodings, FSM state enum and
// the load lane-alignment check used at accept time.
package wb_pkg;

  localparam logic [1:0] SRC_ALU  = 2'd0;
  localparam logic [1:0] SRC_MEM  = 2'd1;
  localparam logic [1:0] SRC_LINK = 2'd2;
  localparam logic [1:0] SRC_IMM  = 2'd3;

  localparam logic [1:0] LD_BYTE  = 2'd0;
  localparam logic [1:0] LD_HALF  = 2'd1;
  localparam logic [1:0] LD_WORD  = 2'd2;
  localparam logic [1:0] LD_DWORD = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_e;

  // True when a load of the given size at the given byte offset is legal.
  // The offset is zero-extended to 3 bits by the caller so one function
  // serves both 32- and 64-bit datapaths; doublewords exist only on 64-bit.
  function automatic logic ld_aligned(input logic [1:0] size,
                                      input logic [2:0] off,
                                      input logic       dw64);
    case (size)
      LD_BYTE: return 1'b1;
      LD_HALF: return ~off[0];
      LD_WORD: return (off[1:0] == 2'b00);
      default: return dw64 && (off == 3'b000);
    endcase
  endfunction

endpackage

// File: rtl/wb_result_unit_load_extract.sv
// Load lane extraction: shifts the addressed lane down and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: i_mem_rdata (little-endian read data), i_size (LD_SIZE encoding),
//        i_unsigned (1 = zero-extend), i_offset (byte offset), o_data (result).
module load_extract
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]         i_mem_rdata,
  input  logic [1:0]                    i_size,
  input  logic                          i_unsigned,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] i_offset,
  output logic [DATA_WIDTH-1:0]         o_data
);

  logic [DATA_WIDTH-1:0] w_shifted;
  logic [DATA_WIDTH-1:0] w_mask;
  logic                  w_sign;

  // Lane starting at byte i_offset moves to bit 0.
  assign w_shifted = i_mem_rdata >> {i_offset, 3'b000};

  // The mask keeps the lane bits; everything above is filled with the
  // extension bit. A full-width lane needs no extension at all.
  always_comb begin
    w_mask = '1;
    w_sign = w_shifted[DATA_WIDTH-1];
    case (i_size)
      LD_BYTE: begin
        w_mask = DATA_WIDTH'(8'hFF);
        w_sign = w_shifted[7];
      end
      LD_HALF: begin
        w_mask = DATA_WIDTH'(16'hFFFF);
        w_sign = w_shifted[15];
      end
      LD_WORD: begin
        w_mask = DATA_WIDTH'(32'hFFFF_FFFF);
        w_sign = w_shifted[31];
      end
      default: begin
        w_mask = '1;
        w_sign = w_shifted[DATA_WIDTH-1];
      end
    endcase
  end

  assign o_data = (w_shifted & w_mask) |
                  ({DATA_WIDTH{w_sign & ~i_unsigned}} & ~w_mask);

endmodule

// File: rtl/wb_result_unit.sv
// Write-back result unit: selects ALU/MEM/LINK/IMM result and drives a registered RF write port.
// Latency: non-load 1 cycle after accept; load 1 cycle after the MEM_RVALID edge.
// Backpressure: i_in_valid/o_in_ready; ready drops for the whole load wait.
//
// Ports: i_clk, i_rst_n (async active-low); request i_in_valid/o_in_ready with
//        i_wb_sel, i_wb_dest, i_ld_size, i_ld_unsigned, i_ld_offset and the
//        source operands; memory response i_mem_rvalid/i_mem_rdata; i_flush;
//        RF port o_rf_we/o_rf_wa/o_rf_wd3; status o_load_busy,
//        o_err_misalign (pulse), o_err_timeout (sticky until reset).
module wb_result_unit
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 15
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_in_valid,
  output logic                            o_in_ready,
  input  logic [1:0]                      i_wb_sel,
  input  logic [REG_ADDR_WIDTH-1:0]       i_wb_dest,
  input  logic [1:0]                      i_ld_size,
  input  logic                            i_ld_unsigned,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] i_ld_offset,
  input  logic [DATA_WIDTH-1:0]           i_alu_result,
  input  logic [DATA_WIDTH-1:0]           i_pc_plus4,
  input  logic [DATA_WIDTH-1:0]           i_imm_upper,
  input  logic                            i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]           i_mem_rdata,
  input  logic                            i_flush,
  output logic                            o_rf_we,
  output logic [REG_ADDR_WIDTH-1:0]       o_rf_wa,
  output logic [DATA_WIDTH-1:0]           o_rf_wd3,
  output logic                            o_load_busy,
  output logic                            o_err_misalign,
  output logic                            o_err_timeout
);

  localparam int OFF_W = $clog2(DATA_WIDTH / 8);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  // The final miss is detected while the counter still holds MEM_TIMEOUT-1,
  // so the timeout fires on exactly the MEM_TIMEOUT-th empty wait cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  wb_state_e               r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [REG_ADDR_WIDTH-1:0] r_ld_dest;
  logic [1:0]              r_ld_size;
  logic                    r_ld_unsigned;
  logic [OFF_W-1:0]        r_ld_offset;
  logic                    r_rf_we;
  logic [REG_ADDR_WIDTH-1:0] r_rf_wa;
  logic [DATA_WIDTH-1:0]   r_rf_wd3;
  logic                    r_err_misalign;
  logic                    r_err_timeout;

  logic                    w_accept;
  logic                    w_is_mem;
  logic                    w_legal;
  logic [DATA_WIDTH-1:0]   w_operand;
  logic [DATA_WIDTH-1:0]   w_ld_data;

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign o_in_ready = i_rst_n & (r_state == ST_IDLE);
  assign w_accept   = i_in_valid & o_in_ready & ~i_flush;
  assign w_is_mem   = (i_wb_sel == SRC_MEM);
  assign w_legal    = ld_aligned(i_ld_size, 3'(i_ld_offset), DATA_WIDTH == 64);

  always_comb begin
    w_operand = i_alu_result;
    case (i_wb_sel)
      SRC_LINK: w_operand = i_pc_plus4;
      SRC_IMM:  w_operand = i_imm_upper;
      default:  w_operand = i_alu_result;
    endcase
  end

  load_extract #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_extract (
    .i_mem_rdata (i_mem_rdata),
    .i_size      (r_ld_size),
    .i_unsigned  (r_ld_unsigned),
    .i_offset    (r_ld_offset),
    .o_data      (w_ld_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_ld_dest      <= '0;
      r_ld_size      <= LD_BYTE;
      r_ld_unsigned  <= 1'b0;
      r_ld_offset    <= '0;
      r_rf_we        <= 1'b0;
      r_rf_wa        <= '0;
      r_rf_wd3       <= '0;
      r_err_misalign <= 1'b0;
      r_err_timeout  <= 1'b0;
    end else begin
      // Write enable and misalign flag are single-cycle pulses.
      r_rf_we        <= 1'b0;
      r_err_misalign <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (!w_is_mem) begin
              r_rf_wa  <= i_wb_dest;
              r_rf_wd3 <= w_operand;
              r_rf_we  <= |i_wb_dest;
            end else if (w_legal) begin
              r_ld_dest     <= i_wb_dest;
              r_ld_size     <= i_ld_size;
              r_ld_unsigned <= i_ld_unsigned;
              r_ld_offset   <= i_ld_offset;
              r_cnt         <= '0;
              r_state       <= ST_WAIT_MEM;
            end else begin
              r_err_misalign <= 1'b1;
            end
          end
        end
        ST_WAIT_MEM: begin
          // Flush outranks a same-cycle response; the response beats timeout.
          if (i_flush) begin
            r_state <= ST_IDLE;
          end else if (i_mem_rvalid) begin
            r_rf_wa  <= r_ld_dest;
            r_rf_wd3 <= w_ld_data;
            r_rf_we  <= |r_ld_dest;
            r_state  <= ST_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_err_timeout <= 1'b1;
            r_state       <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_rf_we        = r_rf_we;
  assign o_rf_wa        = r_rf_wa;
  assign o_rf_wd3       = r_rf_wd3;
  assign o_load_busy    = (r_state == ST_WAIT_MEM);
  assign o_err_misalign = r_err_misalign;
  assign o_err_timeout  = r_err_timeout;

endmodule

// File: tb/tb_wb_result_unit.sv
// Self-checking bench for wb_result_unit (32-bit datapath, MEM_TIMEOUT=4).
// Latency: n/a. Backpressure: n/a.
// Directed scenarios followed by randomized requests checked against a reference model.
module tb_wb_result_unit;
  import wb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    wb_sel = '0;
  logic [AW-1:0] wb_dest = '0;
  logic [1:0]    ld_size = '0;
  logic          ld_unsigned = 1'b0;
  logic [1:0]    ld_offset = '0;
  logic [DW-1:0] alu_result = '0;
  logic [DW-1:0] pc_plus4 = '0;
  logic [DW-1:0] imm_upper = '0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          flush = 1'b0;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd3;
  logic          load_busy;
  logic          err_misalign;
  logic          err_timeout;

  int vectors = 0;
  int miscompares = 0;

  wb_result_unit #(
    .DATA_WIDTH     (DW),
    .REG_ADDR_WIDTH (AW),
    .MEM_TIMEOUT    (TO)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .i_wb_sel       (wb_sel),
    .i_wb_dest      (wb_dest),
    .i_ld_size      (ld_size),
    .i_ld_unsigned  (ld_unsigned),
    .i_ld_offset    (ld_offset),
    .i_alu_result   (alu_result),
    .i_pc_plus4     (pc_plus4),
    .i_imm_upper    (imm_upper),
    .i_mem_rvalid   (mem_rvalid),
    .i_mem_rdata    (mem_rdata),
    .i_flush        (flush),
    .o_rf_we        (rf_we),
    .o_rf_wa        (rf_wa),
    .o_rf_wd3       (rf_wd3),
    .o_load_busy    (load_busy),
    .o_err_misalign (err_misalign),
    .o_err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk5(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then stable for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for exactly one accepting edge.
  task automatic issue(input logic [1:0] sel, input logic [AW-1:0] dest,
                       input logic [1:0] size, input logic uns, input logic [1:0] off,
                       input logic [DW-1:0] alu, input logic [DW-1:0] pc,
                       input logic [DW-1:0] imm);
    wb_sel = sel; wb_dest = dest; ld_size = size; ld_unsigned = uns; ld_offset = off;
    alu_result = alu; pc_plus4 = pc; imm_upper = imm;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Reference model: legality from the alignment rules of a 32-bit datapath.
  function automatic logic m_legal(input logic [1:0] size, input logic [1:0] off);
    if (size == 2'd3) return 1'b0;
    return (int'(off) % (1 << size)) == 0;
  endfunction

  // Reference model: pick the lane arithmetically, then extend.
  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [1:0] size,
                                         input logic uns, input logic [1:0] off);
    longint unsigned bits, v;
    bits = 64'd8 << size;
    v = {32'd0, rd} >> (8 * off);
    v = v & ((64'd1 << bits) - 64'd1);
    if (!uns && v >= (64'd1 << (bits - 64'd1))) v = v - (64'd1 << bits);
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_src(input logic [1:0] sel, input logic [31:0] alu,
                                        input logic [31:0] pc, input logic [31:0] imm);
    if (sel == 2'd2) return pc;
    if (sel == 2'd3) return imm;
    return alu;
  endfunction

  initial begin
    logic [1:0]  r_sel, r_size, r_off;
    logic [4:0]  r_dest;
    logic        r_uns;
    logic [31:0] r_alu, r_pc, r_imm, r_data;
    int          k;

    // Reset state, held asynchronously before any clock edge.
    #3;
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_we", rf_we, 1'b0);
    chk5("rst_wa", rf_wa, 5'd0);
    chk32("rst_wd3", rf_wd3, 32'd0);
    chk1("rst_busy", load_busy, 1'b0);
    chk1("rst_misalign", err_misalign, 1'b0);
    chk1("rst_timeout", err_timeout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk1("post_rst_ready", in_ready, 1'b1);
    step();

    // ALU back-to-back.
    issue(SRC_ALU, 5'd3, 2'd0, 1'b0, 2'd0, 32'h11, 32'h0, 32'h0);
    chk1("alu0_we", rf_we, 1'b1);
    chk5("alu0_wa", rf_wa, 5'd3);
    chk32("alu0_wd", rf_wd3, 32'h11);
    issue(SRC_ALU, 5'd4, 2'd0, 1'b0, 2'd0, 32'h22, 32'h0, 32'h0);
    chk1("alu1_we", rf_we, 1'b1);
    chk5("alu1_wa", rf_wa, 5'd4);
    chk32("alu1_wd", rf_wd3, 32'h22);
    step();
    chk1("alu_idle_we", rf_we, 1'b0);
    chk32("alu_hold_wd", rf_wd3, 32'h22);

    // Signed byte load at offset 2, response on the third edge after accept.
    issue(SRC_MEM, 5'd7, 2'd0, 1'b0, 2'd2, 32'h0, 32'h0, 32'h0);
    chk1("sb_ready_w1", in_ready, 1'b0);
    chk1("sb_busy_w1", load_busy, 1'b1);
    chk1("sb_we_w1", rf_we, 1'b0);
    step();
    chk1("sb_ready_w2", in_ready, 1'b0);
    step();
    chk1("sb_ready_w3", in_ready, 1'b0);
    mem_rdata = 32'h0080_0000; mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    chk1("sb_we", rf_we, 1'b1);
    chk5("sb_wa", rf_wa, 5'd7);
    chk32("sb_wd", rf_wd3, 32'hFFFF_FF80);
    chk1("sb_ready_back", in_ready, 1'b1);
    chk1("sb_busy_clear", load_busy, 1'b0);

    // Misaligned half.
    issue(SRC_MEM, 5'd9, 2'd1, 1'b0, 2'd1, 32'h0, 32'h0, 32'h0);
    chk1("mis_pulse", err_misalign, 1'b1);
    chk1("mis_we", rf_we, 1'b0);
    chk1("mis_ready", in_ready, 1'b1);
    step();
    chk1("mis_pulse_end", err_misalign, 1'b0);

    // LINK to $zero: write suppressed, port data still updates.
    issue(SRC_LINK, 5'd0, 2'd0, 1'b0, 2'd0, 32'h0, 32'h400, 32'h0);
    chk1("zero_we", rf_we, 1'b0);
    chk5("zero_wa", rf_wa, 5'd0);
    chk32("zero_wd", rf_wd3, 32'h400);

    // FLUSH in IDLE blocks the new accept while the registered write issues.
    issue(SRC_IMM, 5'd5, 2'd0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h5500);
    chk1("fi_we_prev", rf_we, 1'b1);
    flush = 1'b1;
    issue(SRC_ALU, 5'd6, 2'd0, 1'b0, 2'd0, 32'h66, 32'h0, 32'h0);
    flush = 1'b0;
    chk1("fi_blocked_we", rf_we, 1'b0);
    chk5("fi_hold_wa", rf_wa, 5'd5);
    chk32("fi_hold_wd", rf_wd3, 32'h5500);

    // FLUSH together with MEM_RVALID during a wait.
    issue(SRC_MEM, 5'd8, 2'd2, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    step();
    chk1("fr_busy", load_busy, 1'b1);
    flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    flush = 1'b0; mem_rvalid = 1'b0;
    chk1("fr_we", rf_we, 1'b0);
    chk1("fr_busy_clear", load_busy, 1'b0);
    chk1("fr_ready", in_ready, 1'b1);
    chk5("fr_hold_wa", rf_wa, 5'd5);

    // Randomized requests against the model.
    for (int n = 0; n < 60; n++) begin
      r_sel = 2'($urandom_range(0, 3));
      r_dest = 5'($urandom);
      r_size = 2'($urandom_range(0, 3));
      r_off = 2'($urandom);
      r_uns = 1'($urandom);
      r_alu = $urandom; r_pc = $urandom; r_imm = $urandom;
      mem_rvalid = 1'($urandom);  // must be ignored while idle
      mem_rdata = $urandom;
      issue(r_sel, r_dest, r_size, r_uns, r_off, r_alu, r_pc, r_imm);
      mem_rvalid = 1'b0;
      if (r_sel != SRC_MEM) begin
        chk1("rnd_src_we", rf_we, r_dest != 5'd0);
        chk5("rnd_src_wa", rf_wa, r_dest);
        chk32("rnd_src_wd", rf_wd3, m_src(r_sel, r_alu, r_pc, r_imm));
      end else if (!m_legal(r_size, r_off)) begin
        chk1("rnd_mis_pulse", err_misalign, 1'b1);
        chk1("rnd_mis_we", rf_we, 1'b0);
      end else begin
        k = $urandom_range(1, TO);
        for (int j = 1; j < k; j++) begin
          chk1("rnd_wait_busy", load_busy, 1'b1);
          step();
        end
        r_data = $urandom;
        mem_rdata = r_data; mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        chk1("rnd_ld_we", rf_we, r_dest != 5'd0);
        chk5("rnd_ld_wa", rf_wa, r_dest);
        chk32("rnd_ld_wd", rf_wd3, m_load(r_data, r_size, r_uns, r_off));
        chk1("rnd_ld_ready", in_ready, 1'b1);
      end
    end
    chk1("rnd_no_timeout", err_timeout, 1'b0);

    // Timeout: four empty wait cycles.
    issue(SRC_MEM, 5'd10, 2'd2, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    for (int j = 0; j < TO - 1; j++) begin
      chk1("to_busy", load_busy, 1'b1);
      chk1("to_not_yet", err_timeout, 1'b0);
      step();
    end
    chk1("to_busy_last", load_busy, 1'b1);
    step();
    chk1("to_set", err_timeout, 1'b1);
    chk1("to_idle", load_busy, 1'b0);
    chk1("to_ready", in_ready, 1'b1);
    chk1("to_no_we", rf_we, 1'b0);
    step(); step();
    chk1("to_sticky", err_timeout, 1'b1);
    issue(SRC_ALU, 5'd11, 2'd0, 1'b0, 2'd0, 32'hAB, 32'h0, 32'h0);
    chk1("to_after_we", rf_we, 1'b1);
    chk32("to_after_wd", rf_wd3, 32'hAB);
    chk1("to_still_set", err_timeout, 1'b1);

    // Reset asserted mid-wait aborts the load asynchronously.
    issue(SRC_MEM, 5'd12, 2'd2, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk1("mr_ready", in_ready, 1'b0);
    chk1("mr_we", rf_we, 1'b0);
    chk5("mr_wa", rf_wa, 5'd0);
    chk32("mr_wd", rf_wd3, 32'd0);
    chk1("mr_busy", load_busy, 1'b0);
    chk1("mr_misalign", err_misalign, 1'b0);
    chk1("mr_timeout", err_timeout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    chk1("mr_after_we", rf_we, 1'b0);
    chk1("mr_after_ready", in_ready, 1'b1);
    chk1("mr_after_busy", load_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
